master_port: RTL

MASTER_PORT -- requirements
Module: master_port

---
 rtl/master_port_pkg.sv | 17 +
 rtl/master_port_if.sv | 24 ++
 rtl/master_in_port.sv | 39 +++
 rtl/master_port.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/master_port_pkg.sv
// Shared definitions for the serial bus master: default widths and FSM state encodings.
package master_port_pkg;

    localparam int DEF_ADDR_W  = 12;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 255;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_STROBE   = 3'd1;
    localparam logic [2:0] ST_WAIT_RDY = 3'd2;
    localparam logic [2:0] ST_SEND     = 3'd3;
    localparam logic [2:0] ST_WAIT_RD  = 3'd4;
    localparam logic [2:0] ST_RECV     = 3'd5;

endpackage

// File: rtl/master_port_if.sv
// Serial bus between master_port and its slave: request strobes, address/data out, read data in.
interface master_port_if;

    logic read_en;
    logic write_en;
    logic slave_ready;
    logic master_valid;
    logic tx_address;
    logic tx_data;
    logic slave_valid;
    logic master_ready;
    logic rx_data;

    modport master (
        output read_en, write_en, master_valid, tx_address, tx_data, master_ready,
        input  slave_ready, slave_valid, rx_data
    );

    modport slave (
        input  read_en, write_en, master_valid, tx_address, tx_data, master_ready,
        output slave_ready, slave_valid, rx_data
    );

endinterface

// File: rtl/master_in_port.sv
// Read-side deserializer: collects DATA_W bits LSB first, advancing only on sampled cycles.
module master_in_port
    import master_port_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              sample,
    input  logic              rx_bit,
    output logic              last,
    output logic [DATA_W-1:0] word_next
);

    localparam int               CNT_W    = $clog2(ADDR_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-2:0] shreg;

    // New bits enter at the MSB so the first bit received ends up at bit 0.
    assign word_next = {rx_bit, shreg};
    assign last      = sample && (bit_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset || clear)
            bit_cnt <= '0;
        else if (sample)
            bit_cnt <= bit_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (sample)
            shreg <= word_next[DATA_W-1:1];
    end

endmodule

// File: rtl/master_port.sv
// Serial bus master: strobes the slave, shifts address/write data out LSB first,
// collects read data through master_in_port, and aborts on a stalled slave.
module master_port
    import master_port_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              mode,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata_out,
    master_port_if.master     bus
);

    localparam int                CNT_W     = $clog2(ADDR_W + 1);
    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  SEND_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mode_q;
    logic [ADDR_W-1:0] addr_sh;
    logic [DATA_W-1:0] wdata_sh;
    logic              rx_active;
    logic              rx_sample;
    logic              rx_last;
    logic [DATA_W-1:0] rx_word;
    logic              timed_out;

    assign rx_active = (state == ST_WAIT_RD) || (state == ST_RECV);
    assign rx_sample = rx_active && bus.slave_valid;
    assign timed_out = (wait_cnt == WAIT_LAST);

    assign busy             = (state != ST_IDLE);
    assign bus.write_en     = (state == ST_STROBE) && mode_q;
    assign bus.read_en      = (state == ST_STROBE) && !mode_q;
    assign bus.master_valid = (state == ST_SEND);
    assign bus.tx_address   = bus.master_valid && addr_sh[0];
    assign bus.tx_data      = bus.master_valid && mode_q && wdata_sh[0];
    assign bus.master_ready = rx_active;

    master_in_port #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_in_port (
        .clk       (clk),
        .reset     (reset),
        .clear     (!rx_active),
        .sample    (rx_sample),
        .rx_bit    (bus.rx_data),
        .last      (rx_last),
        .word_next (rx_word)
    );

    // Request capture and serializers; the write shifter drains to zeros past DATA_W.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req) begin
            mode_q   <= mode;
            addr_sh  <= addr_in;
            wdata_sh <= wdata_in;
        end else if (state == ST_SEND) begin
            addr_sh  <= addr_sh >> 1;
            wdata_sh <= wdata_sh >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            wait_cnt  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata_out <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req)
                        state <= ST_STROBE;
                end
                ST_STROBE: begin
                    state    <= ST_WAIT_RDY;
                    wait_cnt <= '0;
                end
                ST_WAIT_RDY: begin
                    if (bus.slave_ready) begin
                        state   <= ST_SEND;
                        bit_cnt <= '0;
                    end else if (timed_out) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_SEND: begin
                    if (bit_cnt == SEND_LAST) begin
                        if (mode_q) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            state    <= ST_WAIT_RD;
                            wait_cnt <= '0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_RD: begin
                    if (bus.slave_valid) begin
                        if (rx_last) begin
                            rdata_out <= rx_word;
                            done      <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            state <= ST_RECV;
                        end
                    end else if (timed_out) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_RECV: begin
                    if (rx_last) begin
                        rdata_out <= rx_word;
                        done      <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
